// File: rtl/sd_err_int_status_pkg.sv
// Shared definitions for the SD host Error Interrupt Status register (032h):
// bit positions, error category masks and the line-reset recovery states.
package sd_err_int_status_pkg;

   localparam int ERR_CMD_TIMEOUT   = 0;
   localparam int ERR_CMD_CRC       = 1;
   localparam int ERR_CMD_END_BIT   = 2;
   localparam int ERR_CMD_INDEX     = 3;
   localparam int ERR_DAT_TIMEOUT   = 4;
   localparam int ERR_DAT_CRC       = 5;
   localparam int ERR_DAT_END_BIT   = 6;
   localparam int ERR_CURRENT_LIMIT = 7;
   localparam int ERR_AUTO_CMD12    = 8;
   localparam int ERR_ADMA          = 9;
   localparam int ERR_VENDOR_LSB    = 12;

   // Vendor bit 12 doubles as the line-reset acknowledge timeout flag.
   localparam int ERR_RECOVERY_TIMEOUT = ERR_VENDOR_LSB;

   localparam logic [15:0] CMD_ERR_MASK = 16'h010F;
   localparam logic [15:0] DAT_ERR_MASK = 16'h0270;
   localparam logic [15:0] RSV_ERR_MASK = 16'h0C00;
   localparam logic [15:0] HW_ONLY_MASK = 16'h1000;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT_CLR
   } recState_t;

endpackage

// File: rtl/sd_err_recovery_fsm.sv
// CMD/DAT line-reset request sequencer: raises requests on new category errors,
// drops them on acknowledge or timeout, then waits for software to clear status.
module sd_err_recovery_fsm
   import sd_err_int_status_pkg::*;
#(
   parameter int ACK_TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic cmdHit,
   input  logic datHit,
   input  logic cmdPend,
   input  logic datPend,
   input  logic rstAck,
   output logic cmdReq,
   output logic datReq,
   output logic timeoutSet
);

   localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(ACK_TIMEOUT);

   recState_t        state, stateNext;
   logic [CNT_W-1:0] cnt, cntNext;
   logic             cmdReqQ, cmdReqNext;
   logic             datReqQ, datReqNext;
   logic             cmdCap, cmdCapNext;
   logic             datCap, datCapNext;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         cmdReqQ <= 1'b0;
         datReqQ <= 1'b0;
         cmdCap  <= 1'b0;
         datCap  <= 1'b0;
      end else begin
         state   <= stateNext;
         cnt     <= cntNext;
         cmdReqQ <= cmdReqNext;
         datReqQ <= datReqNext;
         cmdCap  <= cmdCapNext;
         datCap  <= datCapNext;
      end
   end

   always_comb begin
      stateNext  = state;
      cntNext    = cnt;
      cmdReqNext = cmdReqQ;
      datReqNext = datReqQ;
      cmdCapNext = cmdCap;
      datCapNext = datCap;
      timeoutSet = 1'b0;
      case (state)
         IDLE: begin
            if (cmdHit || datHit) begin
               stateNext  = REQ;
               cntNext    = '0;
               cmdReqNext = cmdHit;
               datReqNext = datHit;
               cmdCapNext = cmdHit;
               datCapNext = datHit;
            end
         end
         REQ: begin
            cntNext    = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
            cmdCapNext = cmdCap | cmdHit;
            datCapNext = datCap | datHit;
            if (rstAck) begin
               stateNext  = WAIT_CLR;
               cmdReqNext = 1'b0;
               datReqNext = 1'b0;
            end else if (cnt == CNT_LAST) begin
               stateNext  = WAIT_CLR;
               cmdReqNext = 1'b0;
               datReqNext = 1'b0;
               timeoutSet = 1'b1;
            end else begin
               cmdReqNext = cmdReqQ | cmdHit;
               datReqNext = datReqQ | datHit;
            end
         end
         WAIT_CLR: begin
            // Only the categories that triggered this recovery must be cleared.
            if (!(cmdCap && cmdPend) && !(datCap && datPend))
               stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

   assign cmdReq = cmdReqQ;
   assign datReq = datReqQ;

endmodule

// File: rtl/sd_err_int_status.sv
// Error Interrupt Status register (032h): edge-detected sticky error bits with
// write-1-to-clear, interrupt generation and line-reset recovery sequencing.
module sd_err_int_status
   import sd_err_int_status_pkg::*;
#(
   parameter int WIDTH       = 16,
   parameter int ACK_TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] err_evt,
   input  logic [WIDTH-1:0] stat_en,
   input  logic [WIDTH-1:0] sig_en,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rst_ack,
   output logic [WIDTH-1:0] err_status,
   output logic             err_int,
   output logic             irq,
   output logic             cmd_rst_req,
   output logic             dat_rst_req
);

   localparam logic [WIDTH-1:0] RSV_MASK = WIDTH'(RSV_ERR_MASK);
   localparam logic [WIDTH-1:0] EVT_MASK = ~WIDTH'(RSV_ERR_MASK | HW_ONLY_MASK);
   localparam logic [WIDTH-1:0] CMD_MASK = WIDTH'(CMD_ERR_MASK);
   localparam logic [WIDTH-1:0] DAT_MASK = WIDTH'(DAT_ERR_MASK);
   localparam logic [WIDTH-1:0] TMO_BIT  = WIDTH'(1) << ERR_RECOVERY_TIMEOUT;

   logic [WIDTH-1:0] evtPrev;
   logic [WIDTH-1:0] status;
   logic [WIDTH-1:0] setVec;
   logic [WIDTH-1:0] clrVec;
   logic [WIDTH-1:0] statusNext;
   logic             irqQ;
   logic             timeoutSet;

   // Sets are applied after the clear so a same-cycle rise wins over W1C.
   always_comb begin
      setVec     = err_evt & ~evtPrev & stat_en & EVT_MASK;
      clrVec     = wr_en ? wr_data : '0;
      statusNext = ((status & ~clrVec) | setVec | (timeoutSet ? TMO_BIT : '0)) & ~RSV_MASK;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         evtPrev <= '0;
         status  <= '0;
         irqQ    <= 1'b0;
      end else begin
         evtPrev <= err_evt;
         status  <= statusNext;
         irqQ    <= |(statusNext & sig_en);
      end
   end

   sd_err_recovery_fsm #(
      .ACK_TIMEOUT(ACK_TIMEOUT)
   ) uRecovery (
      .clk       (clk),
      .rst       (rst),
      .cmdHit    (|(setVec & CMD_MASK)),
      .datHit    (|(setVec & DAT_MASK)),
      .cmdPend   (|(status & CMD_MASK)),
      .datPend   (|(status & DAT_MASK)),
      .rstAck    (rst_ack),
      .cmdReq    (cmd_rst_req),
      .datReq    (dat_rst_req),
      .timeoutSet(timeoutSet)
   );

   assign err_status = status;
   assign err_int    = |status;
   assign irq        = irqQ;

endmodule

// File: tb/tb_sd_err_int_status.sv
// Table-driven scoreboard bench for sd_err_int_status (ACK_TIMEOUT=4).
module tb_sd_err_int_status;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] err_evt, stat_en, sig_en, wr_data;
   logic        wr_en, rst_ack;
   logic [15:0] err_status;
   logic        err_int, irq, cmd_rst_req, dat_rst_req;

   int nVec = 0;
   int nErr = 0;

   sd_err_int_status #(.WIDTH(16), .ACK_TIMEOUT(4)) dut (
      .clk(clk), .rst(rst), .err_evt(err_evt), .stat_en(stat_en), .sig_en(sig_en),
      .wr_en(wr_en), .wr_data(wr_data), .rst_ack(rst_ack), .err_status(err_status),
      .err_int(err_int), .irq(irq), .cmd_rst_req(cmd_rst_req), .dat_rst_req(dat_rst_req)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        r;
      logic [15:0] evt, sen, gen;
      logic        we;
      logic [15:0] wd;
      logic        ack;
      logic [15:0] es;
      logic        ei, irq, cr, dr;
   } vec_t;

   vec_t tbl[$];
   vec_t sb[$];

   function automatic void addV(logic r, logic [15:0] evt, logic [15:0] sen, logic [15:0] gen,
                                logic we, logic [15:0] wd, logic ack, logic [15:0] es,
                                logic ei, logic ir, logic cr, logic dr);
      vec_t v;
      v.r = r; v.evt = evt; v.sen = sen; v.gen = gen; v.we = we; v.wd = wd; v.ack = ack;
      v.es = es; v.ei = ei; v.irq = ir; v.cr = cr; v.dr = dr;
      tbl.push_back(v);
   endfunction

   task automatic drive(input vec_t v);
      rst = v.r; err_evt = v.evt; stat_en = v.sen; sig_en = v.gen;
      wr_en = v.we; wr_data = v.wd; rst_ack = v.ack;
      sb.push_back(v);
   endtask

   task automatic checkOut(input string name);
      vec_t e;
      nVec++;
      if (sb.size() == 0) begin
         nErr++;
         $display("FAIL %s: scoreboard empty", name);
      end else begin
         e = sb.pop_front();
         if ({err_status, err_int, irq, cmd_rst_req, dat_rst_req} !== {e.es, e.ei, e.irq, e.cr, e.dr}) begin
            nErr++;
            $display("FAIL %s: got status=%h int=%b irq=%b cmd=%b dat=%b, want status=%h int=%b irq=%b cmd=%b dat=%b",
                     name, err_status, err_int, irq, cmd_rst_req, dat_rst_req,
                     e.es, e.ei, e.irq, e.cr, e.dr);
         end
      end
   endtask

   task automatic cmpVal(input string name, input int got, input int want);
      nVec++;
      if (got != want) begin
         nErr++;
         $display("FAIL %s: got %0d want %0d", name, got, want);
      end
   endtask

   localparam logic [15:0] F = 16'hFFFF;

   initial begin
      vec_t v;
      int   hiCnt;
      // r  evt       sen       gen  we wd     ack  status   ei irq cr dr
      addV(1, 16'h0000, F, F, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0); // reset
      addV(1, 16'h0000, F, F, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0);
      addV(0, 16'h0000, F, F, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0);
      addV(0, 16'h0002, F, F, 0, 16'h0000, 0, 16'h0002, 1, 1, 1, 0); // CmdCRC
      addV(0, 16'h0000, F, F, 0, 16'h0000, 0, 16'h0002, 1, 1, 1, 0);
      addV(0, 16'h0000, F, F, 0, 16'h0000, 0, 16'h0002, 1, 1, 1, 0);
      addV(0, 16'h0000, F, F, 0, 16'h0000, 1, 16'h0002, 1, 1, 0, 0); // ack
      addV(0, 16'h0000, F, F, 1, 16'h0002, 0, 16'h0000, 0, 0, 0, 0); // W1C
      addV(0, 16'h0000, F, F, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0);
      addV(0, 16'h0001, F, F, 0, 16'h0000, 0, 16'h0001, 1, 1, 1, 0); // re-request from IDLE
      addV(0, 16'h0000, F, F, 0, 16'h0000, 1, 16'h0001, 1, 1, 0, 0);
      addV(0, 16'h0000, F, F, 1, 16'h0001, 0, 16'h0000, 0, 0, 0, 0);
      addV(0, 16'h0000, F, F, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0);
      addV(0, 16'h0020, F, F, 1, 16'h0020, 0, 16'h0020, 1, 1, 0, 1); // set beats clear
      addV(0, 16'h0000, F, F, 0, 16'h0000, 1, 16'h0020, 1, 1, 0, 0);
      addV(0, 16'h0000, F, F, 1, 16'h0020, 0, 16'h0000, 0, 0, 0, 0);
      addV(0, 16'h0000, F, F, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0);
      addV(0, 16'h0020, 16'hFFDF, F, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0); // stat_en[5]=0
      addV(0, 16'h0000, F, F, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0);
      addV(0, 16'h0010, F, F, 0, 16'h0000, 0, 16'h0010, 1, 1, 0, 1); // held level
      addV(0, 16'h0010, F, F, 0, 16'h0000, 0, 16'h0010, 1, 1, 0, 1);
      addV(0, 16'h0010, F, F, 1, 16'h0010, 0, 16'h0000, 0, 0, 0, 1);
      addV(0, 16'h0010, F, F, 0, 16'h0000, 1, 16'h0000, 0, 0, 0, 0);
      for (int i = 0; i < 6; i++)
         addV(0, 16'h0010, F, F, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0);
      addV(0, 16'h0000, F, F, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0);
      addV(0, 16'h0010, F, F, 0, 16'h0000, 0, 16'h0010, 1, 1, 0, 1); // new rise
      addV(0, 16'h0000, F, F, 0, 16'h0000, 1, 16'h0010, 1, 1, 0, 0);
      addV(0, 16'h0000, F, F, 1, 16'h0010, 0, 16'h0000, 0, 0, 0, 0);
      addV(0, 16'h0000, F, F, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0);
      addV(0, 16'h0200, F, 16'h0000, 0, 16'h0000, 0, 16'h0200, 1, 0, 0, 1); // sig_en=0
      addV(0, 16'h0000, F, 16'h0000, 0, 16'h0000, 1, 16'h0200, 1, 0, 0, 0);
      addV(0, 16'h0000, F, 16'h0000, 1, 16'h0200, 0, 16'h0000, 0, 0, 0, 0);
      addV(0, 16'h0000, F, F, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0);
      addV(0, 16'h0010, F, F, 0, 16'h0000, 0, 16'h0010, 1, 1, 0, 1); // timeout
      addV(0, 16'h0000, F, F, 0, 16'h0000, 0, 16'h0010, 1, 1, 0, 1);
      addV(0, 16'h0000, F, F, 0, 16'h0000, 0, 16'h0010, 1, 1, 0, 1);
      addV(0, 16'h0000, F, F, 0, 16'h0000, 0, 16'h0010, 1, 1, 0, 1);
      addV(0, 16'h0000, F, F, 0, 16'h0000, 0, 16'h1010, 1, 1, 0, 0);
      addV(0, 16'h0000, F, F, 1, 16'h1010, 0, 16'h0000, 0, 0, 0, 0);
      addV(0, 16'h0000, F, F, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0);
      addV(0, 16'h0001, F, F, 0, 16'h0000, 0, 16'h0001, 1, 1, 1, 0); // reset mid-REQ
      addV(0, 16'h0000, F, F, 0, 16'h0000, 0, 16'h0001, 1, 1, 1, 0);
      addV(1, 16'h0002, F, F, 1, 16'h0001, 0, 16'h0000, 0, 0, 0, 0);
      addV(0, 16'h0002, F, F, 0, 16'h0000, 0, 16'h0002, 1, 1, 1, 0); // high at release
      addV(0, 16'h0000, F, F, 0, 16'h0000, 1, 16'h0002, 1, 1, 0, 0);
      addV(0, 16'h0000, F, F, 1, 16'h0002, 0, 16'h0000, 0, 0, 0, 0);
      addV(0, 16'h0000, F, F, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0);
      addV(0, 16'h0C00, F, F, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0); // reserved
      addV(0, 16'h0000, F, F, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0);
      addV(0, 16'h2000, F, F, 0, 16'h0000, 0, 16'h2000, 1, 1, 0, 0); // vendor bit 13
      addV(0, 16'h0000, F, F, 1, 16'h2000, 0, 16'h0000, 0, 0, 0, 0);
      addV(0, 16'h1000, F, F, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0); // bit 12 input ignored
      addV(0, 16'h0000, F, F, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0);
      addV(0, 16'h0080, F, F, 0, 16'h0000, 0, 16'h0080, 1, 1, 0, 0); // stat_en drop keeps bit
      addV(0, 16'h0000, 16'h0000, F, 0, 16'h0000, 0, 16'h0080, 1, 1, 0, 0);
      addV(0, 16'h0000, F, F, 1, 16'h0080, 0, 16'h0000, 0, 0, 0, 0);
      addV(0, 16'h0001, F, F, 0, 16'h0000, 0, 16'h0001, 1, 1, 1, 0); // OR-in during REQ
      addV(0, 16'h0040, F, F, 0, 16'h0000, 0, 16'h0041, 1, 1, 1, 1);
      addV(0, 16'h0000, F, F, 0, 16'h0000, 1, 16'h0041, 1, 1, 0, 0);
      addV(0, 16'h0000, F, F, 1, 16'h0001, 0, 16'h0040, 1, 1, 0, 0);
      addV(0, 16'h0000, F, F, 0, 16'h0000, 0, 16'h0040, 1, 1, 0, 0);
      addV(0, 16'h0008, F, F, 0, 16'h0000, 0, 16'h0048, 1, 1, 0, 0); // no re-request in WAIT_CLR
      addV(0, 16'h0000, F, F, 1, 16'h0048, 0, 16'h0000, 0, 0, 0, 0);
      addV(0, 16'h0000, F, F, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0);

      for (int i = 0; i < tbl.size(); i++) begin
         v = tbl[i];
         drive(v);
         @(posedge clk); #1;
         checkOut($sformatf("vec%0d", i));
      end

      // Timeout duration measured directly: requests high exactly 4 cycles.
      err_evt = 16'h0010;
      @(posedge clk); #1;
      err_evt = 16'h0000;
      hiCnt = 0;
      while (dat_rst_req && hiCnt < 20) begin
         hiCnt++;
         @(posedge clk); #1;
      end
      cmpVal("tmo_len", hiCnt, 4);
      cmpVal("tmo_status", int'(err_status), 'h1010);
      cmpVal("tmo_irq", int'(irq), 1);
      wr_en = 1'b1; wr_data = 16'h1010;
      @(posedge clk); #1;
      wr_en = 1'b0; wr_data = 16'h0000;
      cmpVal("tmo_clr", int'(err_status), 0);
      @(posedge clk); #1;
      cmpVal("tmo_idle_req", int'(dat_rst_req), 0);

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
      $finish;
   end

endmodule

// File: doc/sd_err_int_status.md
# sd_err_int_status

Host-controller side of the SD Host Error Interrupt Status register (offset 032h). It turns raw error indications from the command and data engines into sticky, software-clearable status bits, and it raises the error interrupt toward the Normal Interrupt Status summary. It also sequences a CMD/DAT line-reset request/acknowledge handshake after errors. It sits between the error-detecting engines and the register file, paired with the Error Status Enable (036h) and Error Signal Enable (03Ah) registers.

## Interface
Parameters:
- WIDTH, 16, register width.
- ACK_TIMEOUT, 255, cycles to wait for rst_ack before flagging a recovery timeout.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
- err_evt  in  16  raw error levels, bit map per 032h: [15:12] vendor, [11:10] reserved (ignored), [9] ADMA, [8] AutoCMD12, [7] CurrentLimit, [6] DataEndBit, [5] DataCRC, [4] DataTimeout, [3] CmdIndex, [2] CmdEndBit, [1] CmdCRC, [0] CmdTimeout.
- stat_en  in  16  Error Status Enable (036h).
- sig_en  in  16  Error Signal Enable (03Ah).
- wr_en  in  1  register write strobe to 032h.
- wr_data  in  16  write-1-to-clear mask.
- rst_ack  in  1  line-reset done from the software-reset logic.
- err_status  out  16  current 032h contents.
- err_int  out  1  Normal Interrupt Status bit 15 (OR of all status bits).
- irq  out  1  error interrupt request.
- cmd_rst_req  out  1  request CMD line reset.
- dat_rst_req  out  1  request DAT line reset.

## Operation
- Edge detect: evt_prev holds err_evt from the previous cycle. set = err_evt & ~evt_prev & stat_en. A held level sets a bit only once.
- Status update each cycle: status <= (status & ~(wr_en ? wr_data : 0)) | set.
  - Set wins over a clear of the same bit in the same cycle.
  - Bits [11:10] always read 0.
  - When stat_en is 0 for a bit, that bit is not set. A bit that is already set is not cleared by deasserting stat_en.
- err_int = |err_status (combinational from the register).
- irq is registered: irq <= |(status_next & sig_en).
- Categories:
  - cmd category = bits [3:0] and [8].
  - dat category = bits [6:4] and [9].
  - vendor bit 12 is reused as the recovery-timeout flag. It is set by the FSM and is independent of stat_en and err_evt[12].
- Recovery FSM:
  - IDLE: if set hits the cmd or dat category, capture which categories fired into cmd_rst_req/dat_rst_req, clear the counter, go to REQ.
  - REQ: hold the request outputs and increment the counter.
    - rst_ack=1: drop both requests, go to WAIT_CLR.
    - Counter reaches ACK_TIMEOUT-1 with no ack: drop requests, set bit 12, go to WAIT_CLR.
    - New category errors arriving in REQ are OR-ed into the request outputs.
  - WAIT_CLR: wait until every bit in the captured categories reads 0, then go to IDLE. New errors here are latched in status but do not re-request until IDLE is re-entered.
- Counter width is clog2(ACK_TIMEOUT+1). It saturates and never wraps.

## Timing
- Reset values: err_status=0, evt_prev=0, irq=0, err_int=0, cmd_rst_req=0, dat_rst_req=0, FSM=IDLE, counter=0.
- An err_evt bit that is already high when reset releases sets its status bit on the first edge after reset.
- Latency:
  - err_evt rise sampled at edge N: err_status and err_int valid after edge N; irq high after edge N.
  - Requests assert after edge N.
- A W1C write at edge N: bit reads 0 after edge N, and irq falls after edge N if no other enabled bit remains.
- rst_ack sampled at edge M: requests low after edge M.
- Timeout: requests stay high for exactly ACK_TIMEOUT cycles; bit 12 is set on the same edge they drop.
- rst during any state returns all outputs to their reset values on that edge. A pending W1C or event in the same cycle is discarded.

## Structure
- Shared package: bit-index constants for 032h (ERR_CMD_TIMEOUT=0 … ERR_VENDOR_LSB=12), category masks CMD_ERR_MASK=16'h010F and DAT_ERR_MASK=16'h0270, reserved mask 16'h0C00, FSM state enum {IDLE, REQ, WAIT_CLR}.
- One natural sub-module: sd_err_recovery_fsm (state, counter, request outputs). The status/W1C/edge logic stays in the top.

## Test plan
- Reset release with err_evt=0, all enables 1 -> err_status=16'h0000, irq=0, no requests.
- err_evt[1] pulse (CmdCRC), stat_en=sig_en=16'hFFFF -> next cycle err_status=16'h0002, irq=1, err_int=1, cmd_rst_req=1. rst_ack after 3 cycles -> cmd_rst_req drops. W1C 16'h0002 -> status 0, irq 0, FSM IDLE.
- Same-cycle err_evt[5] rise and W1C 16'h0020 -> bit 5 remains set; stat_en[5]=0 with err_evt[5] rise -> bit 5 stays 0.
- err_evt[4] held high 10 cycles and cleared by W1C at cycle 3 -> bit reads 0 afterward; no re-set until the level drops and rises again.
- sig_en=0, stat_en=16'hFFFF, err_evt[9] rise -> status 16'h0200, err_int=1, irq=0, dat_rst_req=1.
- ACK_TIMEOUT=4, dat error, no rst_ack -> dat_rst_req high exactly 4 cycles, then bit 12 set (status 16'h1010 for a bit-4 error). rst asserted mid-REQ -> all outputs 0 next edge.
